test_supervisor: RTL and testbench
==================================

# test_supervisor

Synthesizable, parametrised successor to the simulation test driver: sequences DUT reset, then supervises a run until pass, fail, timeout or hang. It tracks N independent completion/failure channels (for example tile, TSI and DSP checkers) and reports a sticky verdict with a reason code and the failing channel. It sits in the test harness between the clock/reset source and the DUT success/failure indicators. It is usable both in simulation and on FPGA emulation, where no `$finish` exists.

## Interface
- N_CHAN, 4, number of supervised channels (1–32)
- CNT_W, 64, width of the cycle counter and max_cycles
- RESET_CYCLES, 16, cycles dut_reset is held after start (≥1)
- HANG_LIMIT, 1024, run cycles allowed without a progress pulse
- DONE_MODE, 0, 0 = all enabled channels must finish; 1 = any enabled channel finishing passes
- core_clock  in  1  clock
- reset  in  1  synchronous, active-low
- start  in  1  level-sampled; starts a run from IDLE, PASS or FAIL
- max_cycles  in  CNT_W  timeout bound; 0 disables timeout
- chan_en  in  N_CHAN  channel enable mask, sampled every RUN cycle
- chan_done  in  N_CHAN  per-channel success, pulse or level
- chan_fail  in  N_CHAN  per-channel failure, pulse or level
- progress  in  1  heartbeat pulse
- dut_reset  out  1  active-high reset to the DUT
- running  out  1  high in RUN
- finish  out  1  sticky; high in PASS or FAIL
- failed  out  1  sticky; high in FAIL
- reason  out  3  0 NONE, 1 CHAN_FAIL, 2 HANG, 3 TIMEOUT, 4 NO_CHAN
- fail_chan  out  $clog2(N_CHAN) (min 1)  lowest failing channel index
- cycle_count  out  CNT_W  cycles since start

## Operation
- FSM states: IDLE, HOLD, RUN, PASS, FAIL.
- IDLE: when start=1, go to HOLD. In the same edge, clear cycle_count, the done flags, reason and fail_chan.
- HOLD: dut_reset=1. A hold counter counts RESET_CYCLES cycles, then the FSM goes to RUN.
- RUN: dut_reset=0 and running=1.
  - Per-channel sticky done flags latch `chan_done & chan_en`.
  - Evaluate in priority order; the first true condition wins:
    1. `chan_en == 0` → FAIL with NO_CHAN.
    2. Any `chan_fail & chan_en` → FAIL with CHAN_FAIL; fail_chan = lowest such index.
    3. Idle counter ≥ HANG_LIMIT → FAIL with HANG.
    4. `max_cycles != 0` and registered cycle_count > max_cycles → FAIL with TIMEOUT.
    5. Done condition met → PASS.
  - Done condition: DONE_MODE 0 requires `(flags | new done) & chan_en == chan_en`. DONE_MODE 1 requires any enabled flag or new done.
  - A failure and a completion in the same cycle → FAIL.
- PASS / FAIL: terminal. dut_reset stays 0; cycle_count and reason are frozen. start=1 re-enters HOLD with all flags cleared.
- cycle_count increments every cycle in HOLD and RUN. It saturates at all-ones and never wraps.
- Idle counter:
  - Clears on RUN entry and on any cycle with progress=1.
  - Increments otherwise while in RUN.
  - Saturates at HANG_LIMIT.
- reset=0 at any edge, including mid-run: go to IDLE with dut_reset=1. All other outputs, counters and flags go to 0.

## Timing
- Reset values: dut_reset=1; running, finish, failed, reason, fail_chan, cycle_count all 0.
- All outputs are registered, with no combinational input-to-output path.
- Latency start→HOLD is 1 cycle. dut_reset deasserts exactly RESET_CYCLES+1 edges after start is sampled.
- A verdict is visible 1 cycle after the deciding inputs are sampled. Done or fail inputs seen in HOLD are ignored.
- A channel whose chan_en drops mid-run is no longer required. Its latched flag is retained but masked.

## Configuration
- TEST_SUPERVISOR_HANG_DETECT_EN defined: idle counter and HANG reason are implemented as described.
- Macro not defined: the idle counter is not built, progress is ignored, and reason never takes the value 2.

## Structure
- Package test_supervisor_pkg holds the FSM state enum, the reason enum (3-bit) and the reason encodings.
- Sub-module test_supervisor_chan_tracker holds the sticky done flags and produces three results:
  - the all/any done reduction per DONE_MODE;
  - an any-fail flag;
  - a lowest-index priority encoder for fail_chan.
- The top level holds the FSM, the hold counter, the cycle counter and the idle counter.

## Test plan
- RESET_CYCLES=4; start pulse → dut_reset high for 4 HOLD cycles and falls on the 5th edge after start; running rises on that same edge.
- N_CHAN=4, chan_en=4'b1011, DONE_MODE 0; done pulses on channels 0, 1, 3 in separate cycles → PASS one cycle after channel 3; reason=0, finish=1, failed=0.
- In RUN, chan_fail=4'b0110 in the same cycle as the final done pulse → FAIL, reason=1, fail_chan=1.
- max_cycles=10, RESET_CYCLES=4, no done → FAIL with reason=3 and cycle_count frozen at 11.
- Macro defined, HANG_LIMIT=8, no progress and max_cycles=0 → FAIL with reason=2 after 8 RUN cycles. With a progress pulse every 5 cycles, no hang occurs.
- reset driven low mid-RUN → next edge gives IDLE, dut_reset=1 and all outputs 0. A later start runs the sequence normally.

Source files
------------

// File: rtl/test_supervisor_pkg.sv
// Shared types for the test supervisor: FSM states, verdict reason codes and a
// width helper for channel indices.
package test_supervisor_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_RUN  = 3'd2,
    ST_PASS = 3'd3,
    ST_FAIL = 3'd4
  } state_t;

  localparam logic [2:0] REASON_NONE      = 3'd0;
  localparam logic [2:0] REASON_CHAN_FAIL = 3'd1;
  localparam logic [2:0] REASON_HANG      = 3'd2;
  localparam logic [2:0] REASON_TIMEOUT   = 3'd3;
  localparam logic [2:0] REASON_NO_CHAN   = 3'd4;

  typedef enum logic [2:0] {
    RSN_NONE      = REASON_NONE,
    RSN_CHAN_FAIL = REASON_CHAN_FAIL,
    RSN_HANG      = REASON_HANG,
    RSN_TIMEOUT   = REASON_TIMEOUT,
    RSN_NO_CHAN   = REASON_NO_CHAN
  } reason_t;

  // A single channel still needs a one-bit index port.
  function automatic int chan_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/test_supervisor_if.sv
// Harness-side bundle between the stimulus/checkers and the supervisor; the
// supervisor uses the slave modport, the harness drives through master.
interface test_supervisor_if
  import test_supervisor_pkg::*;
#(
  parameter int N_CHAN = 4,
  parameter int CNT_W  = 64
);
  localparam int FC_W = chan_idx_w(N_CHAN);

  logic              start;
  logic [CNT_W-1:0]  max_cycles;
  logic [N_CHAN-1:0] chan_en;
  logic [N_CHAN-1:0] chan_done;
  logic [N_CHAN-1:0] chan_fail;
  logic              progress;

  logic              dut_reset;
  logic              running;
  logic              finish;
  logic              failed;
  reason_t           reason;
  logic [FC_W-1:0]   fail_chan;
  logic [CNT_W-1:0]  cycle_count;

  modport master (
    output start, max_cycles, chan_en, chan_done, chan_fail, progress,
    input  dut_reset, running, finish, failed, reason, fail_chan, cycle_count
  );

  modport slave (
    input  start, max_cycles, chan_en, chan_done, chan_fail, progress,
    output dut_reset, running, finish, failed, reason, fail_chan, cycle_count
  );

endinterface

// File: rtl/test_supervisor_chan_tracker.sv
// Sticky per-channel done flags plus combinational done/any-fail/lowest-fail
// results for the current cycle; flags only latch while the supervisor runs.
module test_supervisor_chan_tracker #(
  parameter int N_CHAN    = 4,
  parameter int DONE_MODE = 0,
  parameter int FC_W      = 2
) (
  input  logic              core_clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              latch,
  input  logic [N_CHAN-1:0] chan_en,
  input  logic [N_CHAN-1:0] chan_done,
  input  logic [N_CHAN-1:0] chan_fail,
  output logic              done_met,
  output logic              any_fail,
  output logic [FC_W-1:0]   fail_idx
);

  logic [N_CHAN-1:0] flags;
  logic [N_CHAN-1:0] seen;
  logic [N_CHAN-1:0] fails;

  always_ff @(posedge core_clock) begin
    if (!reset) begin
      flags <= '0;
    end else if (clear) begin
      flags <= '0;
    end else if (latch) begin
      flags <= flags | (chan_done & chan_en);
    end
  end

  // Disabled channels keep their flag but no longer count toward completion.
  assign seen  = (flags | (chan_done & chan_en)) & chan_en;
  assign fails = chan_fail & chan_en;

  generate
    if (DONE_MODE == 0) begin : g_all
      assign done_met = (seen == chan_en);
    end else begin : g_any
      assign done_met = |seen;
    end
  endgenerate

  assign any_fail = |fails;

  always_comb begin
    fail_idx = '0;
    for (int i = N_CHAN - 1; i >= 0; i--) begin
      if (fails[i]) fail_idx = FC_W'(i);
    end
  end

endmodule

// File: rtl/test_supervisor.sv
// Resets the DUT, then supervises the run to a sticky PASS/FAIL verdict one cycle after the deciding inputs.
// Hang detection (idle counter, HANG reason) is built only with TEST_SUPERVISOR_HANG_DETECT_EN defined.
module test_supervisor
  import test_supervisor_pkg::*;
#(
  parameter int N_CHAN       = 4,
  parameter int CNT_W        = 64,
  parameter int RESET_CYCLES = 16,
  parameter int HANG_LIMIT   = 1024,
  parameter int DONE_MODE    = 0
) (
  input  logic core_clock,
  input  logic reset,
  test_supervisor_if.slave bus
);

  localparam int FC_W = chan_idx_w(N_CHAN);
  localparam int HW   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);

  state_t           state;
  logic [HW-1:0]    hold_cnt;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] cycle_next;
  logic             dut_reset_q;
  logic             running_q;
  logic             finish_q;
  logic             failed_q;
  reason_t          reason_q;
  logic [FC_W-1:0]  fail_chan_q;

  logic             start_take;
  logic             in_run;
  logic             done_met;
  logic             any_fail;
  logic [FC_W-1:0]  fail_idx;
  logic             hang_hit;
  logic             timeout_hit;
  logic             run_fail;
  reason_t          run_reason;

  assign in_run     = (state == ST_RUN);
  assign start_take = bus.start &&
                      ((state == ST_IDLE) || (state == ST_PASS) || (state == ST_FAIL));

  test_supervisor_chan_tracker #(
    .N_CHAN    (N_CHAN),
    .DONE_MODE (DONE_MODE),
    .FC_W      (FC_W)
  ) u_tracker (
    .core_clock (core_clock),
    .reset      (reset),
    .clear      (start_take),
    .latch      (in_run),
    .chan_en    (bus.chan_en),
    .chan_done  (bus.chan_done),
    .chan_fail  (bus.chan_fail),
    .done_met   (done_met),
    .any_fail   (any_fail),
    .fail_idx   (fail_idx)
  );

`ifdef TEST_SUPERVISOR_HANG_DETECT_EN
  localparam int IW = $clog2(HANG_LIMIT + 1);
  logic [IW-1:0] idle_cnt;

  // Held at zero outside RUN, so it is already clear on RUN entry.
  always_ff @(posedge core_clock) begin
    if (!reset) begin
      idle_cnt <= '0;
    end else if (!in_run || bus.progress) begin
      idle_cnt <= '0;
    end else if (idle_cnt < IW'(HANG_LIMIT)) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

  assign hang_hit = (idle_cnt >= IW'(HANG_LIMIT));
`else
  localparam int unused_hang_limit = HANG_LIMIT;
  logic unused_progress;
  assign unused_progress = bus.progress;
  assign hang_hit        = 1'b0;
`endif

  assign timeout_hit = (bus.max_cycles != '0) && (cycle_cnt > bus.max_cycles);
  assign cycle_next  = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_W'(1);

  always_comb begin
    run_fail   = 1'b1;
    run_reason = RSN_NONE;
    if (bus.chan_en == '0)  run_reason = RSN_NO_CHAN;
    else if (any_fail)      run_reason = RSN_CHAN_FAIL;
    else if (hang_hit)      run_reason = RSN_HANG;
    else if (timeout_hit)   run_reason = RSN_TIMEOUT;
    else                    run_fail   = 1'b0;
  end

  always_ff @(posedge core_clock) begin
    if (!reset) begin
      state       <= ST_IDLE;
      hold_cnt    <= '0;
      cycle_cnt   <= '0;
      dut_reset_q <= 1'b1;
      running_q   <= 1'b0;
      finish_q    <= 1'b0;
      failed_q    <= 1'b0;
      reason_q    <= RSN_NONE;
      fail_chan_q <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_PASS, ST_FAIL: begin
          if (bus.start) begin
            state       <= ST_HOLD;
            hold_cnt    <= '0;
            cycle_cnt   <= '0;
            dut_reset_q <= 1'b1;
            running_q   <= 1'b0;
            finish_q    <= 1'b0;
            failed_q    <= 1'b0;
            reason_q    <= RSN_NONE;
            fail_chan_q <= '0;
          end
        end
        ST_HOLD: begin
          cycle_cnt <= cycle_next;
          if (hold_cnt == HOLD_LAST) begin
            state       <= ST_RUN;
            dut_reset_q <= 1'b0;
            running_q   <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ST_RUN: begin
          // The verdict edge leaves cycle_count frozen at its last RUN value.
          if (run_fail) begin
            state       <= ST_FAIL;
            running_q   <= 1'b0;
            finish_q    <= 1'b1;
            failed_q    <= 1'b1;
            reason_q    <= run_reason;
            fail_chan_q <= (run_reason == RSN_CHAN_FAIL) ? fail_idx : '0;
          end else if (done_met) begin
            state     <= ST_PASS;
            running_q <= 1'b0;
            finish_q  <= 1'b1;
          end else begin
            cycle_cnt <= cycle_next;
          end
        end
        default: begin
          state       <= ST_IDLE;
          dut_reset_q <= 1'b1;
          running_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dut_reset   = dut_reset_q;
  assign bus.running     = running_q;
  assign bus.finish      = finish_q;
  assign bus.failed      = failed_q;
  assign bus.reason      = reason_q;
  assign bus.fail_chan   = fail_chan_q;
  assign bus.cycle_count = cycle_cnt;

endmodule

// File: tb/tb_test_supervisor.sv
// Drives two supervisors (all-done and any-done) with directed and random runs
// and compares every output each cycle against an edge-counting reference model.
module tb_test_supervisor;
  import test_supervisor_pkg::*;

  localparam int N_CHAN       = 4;
  localparam int CNT_W        = 32;
  localparam int RESET_CYCLES = 4;
  localparam int HANG_LIMIT   = 8;
`ifdef TEST_SUPERVISOR_HANG_DETECT_EN
  localparam bit HANG_EN = 1'b1;
`else
  localparam bit HANG_EN = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_HOLD = 1;
  localparam int P_RUN  = 2;
  localparam int P_OVER = 3;

  logic             core_clock = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] max_cycles;
  logic [3:0]       chan_en;
  logic [3:0]       chan_done;
  logic [3:0]       chan_fail;
  logic             progress;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_no = 0;

  test_supervisor_if #(.N_CHAN(N_CHAN), .CNT_W(CNT_W)) bus_all ();
  test_supervisor_if #(.N_CHAN(N_CHAN), .CNT_W(CNT_W)) bus_any ();

  assign bus_all.start      = start;
  assign bus_all.max_cycles = max_cycles;
  assign bus_all.chan_en    = chan_en;
  assign bus_all.chan_done  = chan_done;
  assign bus_all.chan_fail  = chan_fail;
  assign bus_all.progress   = progress;
  assign bus_any.start      = start;
  assign bus_any.max_cycles = max_cycles;
  assign bus_any.chan_en    = chan_en;
  assign bus_any.chan_done  = chan_done;
  assign bus_any.chan_fail  = chan_fail;
  assign bus_any.progress   = progress;

  test_supervisor #(
    .N_CHAN(N_CHAN), .CNT_W(CNT_W), .RESET_CYCLES(RESET_CYCLES),
    .HANG_LIMIT(HANG_LIMIT), .DONE_MODE(0)
  ) dut_all (
    .core_clock (core_clock),
    .reset      (reset),
    .bus        (bus_all.slave)
  );

  test_supervisor #(
    .N_CHAN(N_CHAN), .CNT_W(CNT_W), .RESET_CYCLES(RESET_CYCLES),
    .HANG_LIMIT(HANG_LIMIT), .DONE_MODE(1)
  ) dut_any (
    .core_clock (core_clock),
    .reset      (reset),
    .bus        (bus_any.slave)
  );

  always #5 core_clock = ~core_clock;

  typedef struct {
    int     phase;
    int     start_edge;
    int     last_clear;
    longint cyc;
    logic [3:0] flags;
    logic   dut_reset;
    logic   running;
    logic   finish;
    logic   failed;
    int     reason;
    int     fail_chan;
  } model_t;

  model_t mdl [2];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @edge %0d: got %0d expected %0d", tag, edge_no, got, exp);
    end
  endtask

  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  // k selects the completion rule: 0 = every enabled channel, 1 = any enabled channel.
  task automatic model_step(input int k);
    model_t     m;
    int         idle;
    longint     cyc_reg;
    int         rsn;
    logic [3:0] seen;
    logic [3:0] fl;
    bit         done_ok;
    m = mdl[k];
    if (!reset) begin
      m.phase = P_IDLE; m.cyc = 0; m.flags = 0; m.dut_reset = 1; m.running = 0;
      m.finish = 0; m.failed = 0; m.reason = 0; m.fail_chan = 0;
    end else begin
      case (m.phase)
        P_IDLE, P_OVER: if (start) begin
          m.phase = P_HOLD; m.start_edge = edge_no; m.cyc = 0; m.flags = 0;
          m.dut_reset = 1; m.running = 0; m.finish = 0; m.failed = 0;
          m.reason = 0; m.fail_chan = 0;
        end
        P_HOLD: begin
          m.cyc = edge_no - m.start_edge;
          if (edge_no - m.start_edge == RESET_CYCLES) begin
            m.phase = P_RUN; m.dut_reset = 0; m.running = 1; m.last_clear = edge_no;
          end
        end
        default: begin
          idle    = edge_no - 1 - m.last_clear;
          if (idle > HANG_LIMIT) idle = HANG_LIMIT;
          cyc_reg = edge_no - 1 - m.start_edge;
          fl      = chan_fail & chan_en;
          seen    = (m.flags | (chan_done & chan_en)) & chan_en;
          done_ok = (k == 0) ? (seen == chan_en) : (seen != 0);
          rsn = 0;
          if (chan_en == 0)                              rsn = 4;
          else if (fl != 0)                              rsn = 1;
          else if (HANG_EN && idle >= HANG_LIMIT)        rsn = 2;
          else if (max_cycles != 0 && cyc_reg > max_cycles) rsn = 3;
          if (rsn != 0) begin
            m.phase = P_OVER; m.running = 0; m.finish = 1; m.failed = 1;
            m.reason = rsn; m.fail_chan = (rsn == 1) ? lowest(fl) : 0;
          end else if (done_ok) begin
            m.phase = P_OVER; m.running = 0; m.finish = 1;
          end else begin
            m.cyc   = cyc_reg + 1;
            m.flags = m.flags | (chan_done & chan_en);
            if (progress) m.last_clear = edge_no;
          end
        end
      endcase
    end
    mdl[k] = m;
  endtask

  task automatic cmp_inst(input string nm, input int k, input logic dr, input logic run,
                          input logic fin, input logic fld, input logic [2:0] rsn,
                          input logic [1:0] fc, input logic [CNT_W-1:0] cc);
    check_eq({nm, ".dut_reset"},   dr,  mdl[k].dut_reset);
    check_eq({nm, ".running"},     run, mdl[k].running);
    check_eq({nm, ".finish"},      fin, mdl[k].finish);
    check_eq({nm, ".failed"},      fld, mdl[k].failed);
    check_eq({nm, ".reason"},      rsn, mdl[k].reason);
    check_eq({nm, ".fail_chan"},   fc,  mdl[k].fail_chan);
    check_eq({nm, ".cycle_count"}, cc,  mdl[k].cyc);
  endtask

  task automatic tick();
    @(posedge core_clock);
    edge_no++;
    model_step(0);
    model_step(1);
    #1;
    cmp_inst("all", 0, bus_all.dut_reset, bus_all.running, bus_all.finish, bus_all.failed,
             bus_all.reason, bus_all.fail_chan, bus_all.cycle_count);
    cmp_inst("any", 1, bus_any.dut_reset, bus_any.running, bus_any.finish, bus_any.failed,
             bus_any.reason, bus_any.fail_chan, bus_any.cycle_count);
  endtask

  task automatic launch();
    start = 1; tick(); start = 0;
    repeat (RESET_CYCLES) tick();
  endtask

  initial begin
    int cnt;
    reset = 0; start = 0; max_cycles = 0; chan_en = 0; chan_done = 0; chan_fail = 0; progress = 0;
    repeat (3) tick();
    reset = 1;
    tick();

    // Hold length: dut_reset falls on the 5th edge after start, running rises with it.
    chan_en = 4'b1011;
    start = 1; tick(); start = 0;
    cnt = 1;
    while (bus_all.dut_reset && cnt < 20) begin tick(); cnt++; end
    check_eq("hold_edges", cnt, RESET_CYCLES + 1);
    check_eq("run_rise", bus_all.running, 1);

    // All-done completion over separate pulses on channels 0, 1, 3.
    chan_done = 4'b0001; tick(); chan_done = 0; tick();
    chan_done = 4'b0010; tick(); chan_done = 0; tick();
    check_eq("pass_early", bus_all.finish, 0);
    chan_done = 4'b1000; tick(); chan_done = 0;
    check_eq("pass_finish", bus_all.finish, 1);
    check_eq("pass_failed", bus_all.failed, 0);
    check_eq("pass_reason", bus_all.reason, 0);

    // Failure wins over the completing done pulse.
    launch();
    chan_done = 4'b0011; tick();
    chan_done = 4'b1000; chan_fail = 4'b0110; tick();
    chan_done = 0; chan_fail = 0;
    check_eq("cf_failed", bus_all.failed, 1);
    check_eq("cf_reason", bus_all.reason, 1);
    check_eq("cf_chan", bus_all.fail_chan, 1);

    // Timeout with steady heartbeat.
    max_cycles = 10;
    start = 1; tick(); start = 0;
    cnt = 0;
    while (!bus_all.finish && cnt < 40) begin progress = ~progress; tick(); cnt++; end
    progress = 0;
    check_eq("to_reason", bus_all.reason, 3);
    check_eq("to_cycles", bus_all.cycle_count, 11);

    // No heartbeat and no timeout.
    max_cycles = 0;
    start = 1; tick(); start = 0;
    cnt = 0;
    while (!bus_all.finish && cnt < 30) begin tick(); cnt++; end
    if (HANG_EN) check_eq("hang_reason", bus_all.reason, 2);
    else         check_eq("nohang_running", bus_all.running, 1);

    // Heartbeat every 5 cycles keeps the run alive; then reset mid-run.
    start = 1; tick(); start = 0;
    for (int i = 0; i < 40; i++) begin progress = (i % 5 == 0); tick(); end
    progress = 0;
    check_eq("beat_running", bus_all.running, 1);
    reset = 0; tick(); reset = 1;
    check_eq("mid_rst_dut_reset", bus_all.dut_reset, 1);
    check_eq("mid_rst_running", bus_all.running, 0);
    check_eq("mid_rst_cycles", bus_all.cycle_count, 0);

    // Random runs.
    for (int run = 0; run < 60; run++) begin
      int pprob;
      chan_en    = 4'($urandom_range(0, 15));
      max_cycles = ($urandom_range(0, 2) == 0) ? 0 : CNT_W'($urandom_range(5, 30));
      pprob      = $urandom_range(0, 3);
      start = 1; tick(); start = 0;
      cnt = 0;
      while (!(bus_all.finish && bus_any.finish) && cnt < 120) begin
        for (int b = 0; b < 4; b++) begin
          chan_done[b] = ($urandom_range(0, 5) == 0);
          chan_fail[b] = ($urandom_range(0, 39) == 0);
        end
        progress = (pprob != 0) && ($urandom_range(0, pprob) == 0);
        start    = ($urandom_range(0, 49) == 0);
        if ($urandom_range(0, 19) == 0) chan_en = 4'($urandom_range(0, 15));
        reset    = ($urandom_range(0, 149) != 0);
        tick();
        reset = 1;
        cnt++;
      end
      chan_done = 0; chan_fail = 0; progress = 0; start = 0;
      repeat (2) tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
